// File: rtl/iommu_msi_addr_deposit.sv
// MSI target address builder: scatters interrupt-file number bits into the set
// positions of the MSI address mask, LANES mask positions per cycle.
module iommu_msi_addr_deposit #(
  parameter int MSI_MASK_LEN = 52,
  parameter int LANES        = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [MSI_MASK_LEN-1:0] mask_i,
  input  logic [MSI_MASK_LEN-1:0] pattern_i,
  input  logic [MSI_MASK_LEN-1:0] file_num_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [MSI_MASK_LEN-1:0] gpa_ppn_o,
  output logic                    err_o
);

  localparam int KW      = $clog2(MSI_MASK_LEN + 1);
  localparam int RUN_CYC = (MSI_MASK_LEN + LANES - 1) / LANES;
  localparam int POS_MAX = RUN_CYC * LANES;
  localparam int PW      = $clog2(POS_MAX + 1);
  localparam logic [MSI_MASK_LEN-1:0] ONE = MSI_MASK_LEN'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  r_state;
  logic [MSI_MASK_LEN-1:0] r_mask;
  logic [MSI_MASK_LEN-1:0] r_num;
  logic [MSI_MASK_LEN-1:0] r_acc;
  logic [PW-1:0]           r_pos;
  logic [KW-1:0]           r_k;
  logic                    r_err;
  logic                    r_out_valid;
  logic                    r_in_ready;

  logic [MSI_MASK_LEN-1:0] w_acc;
  logic [KW-1:0]           w_k;
  logic [31:0]             w_sh;
  logic                    w_err;
  logic                    w_last;
  logic [PW-1:0]           w_pos_nxt;

  // One RUN step: lanes are walked in ascending bit order so k tracks the
  // number of mask bits consumed so far within this cycle as well.
  always_comb begin
    w_acc = r_acc;
    w_k   = r_k;
    w_sh  = '0;
    for (int l = 0; l < LANES; l++) begin
      w_sh = 32'(r_pos) + 32'(l);
      if (w_sh < 32'(MSI_MASK_LEN) && |(r_mask & (ONE << w_sh))) begin
        w_acc = (w_acc & ~(ONE << w_sh)) |
                ((|(r_num & (ONE << w_k))) ? (ONE << w_sh) : '0);
        w_k   = w_k + KW'(1);
      end
    end
    // Any file-number bit with no mask slot left is lost.
    w_err     = |(r_num >> w_k);
    w_last    = (32'(r_pos) + 32'(LANES)) >= 32'(MSI_MASK_LEN);
    w_pos_nxt = ((32'(r_pos) + 32'(LANES)) >= 32'(POS_MAX)) ?
                PW'(POS_MAX) : PW'(32'(r_pos) + 32'(LANES));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_mask      <= '0;
      r_num       <= '0;
      r_acc       <= '0;
      r_pos       <= '0;
      r_k         <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid_i && r_in_ready) begin
            r_mask     <= mask_i;
            r_num      <= file_num_i;
            r_acc      <= pattern_i & ~mask_i;
            r_pos      <= '0;
            r_k        <= '0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_acc;
          r_k   <= w_k;
          r_pos <= w_pos_nxt;
          if (w_last) begin
            r_err       <= w_err;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign gpa_ppn_o   = r_acc & {MSI_MASK_LEN{r_out_valid}};
  assign err_o       = r_err & r_out_valid;

endmodule

// File: tb/tb_iommu_msi_addr_deposit.sv
// Bench for iommu_msi_addr_deposit: table vectors, random vectors against a
// bit-serial reference, DONE back-pressure and mid-RUN reset.
module tb_iommu_msi_addr_deposit;
  localparam int N   = 52;
  localparam int LAT = 14;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, err;
  logic [N-1:0] mask, pattern, file_num, gpa;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [N-1:0] gpa; logic err;} exp_t;
  exp_t sb[$];

  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0] pat;
    logic [N-1:0] num;
    logic [N-1:0] gpa;
    logic         err;
    int           hold;
  } vec_t;
  vec_t tbl[8];

  iommu_msi_addr_deposit #(.MSI_MASK_LEN(N), .LANES(4)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mask_i(mask), .pattern_i(pattern), .file_num_i(file_num),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .gpa_ppn_o(gpa), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] model_gpa(input logic [N-1:0] m, p, n);
    logic [N-1:0] r, t;
    int j;
    r = p & ~m;
    j = 0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        t    = n >> j;
        r[i] = t[0];
        j++;
      end
    end
    return r;
  endfunction

  function automatic logic model_err(input logic [N-1:0] m, n);
    int c;
    c = $countones(m);
    return (c < N) ? |(n >> c) : 1'b0;
  endfunction

  task automatic txn(input logic [N-1:0] m, p, n, input logic [N-1:0] eg,
                     input logic ee, input int hold, input string nm);
    int   cyc;
    logic early;
    exp_t e, got;
    @(negedge clk);
    mask = m; pattern = p; file_num = n; in_valid = 1'b1; out_ready = 1'b0;
    chk({nm, ":in_ready_idle"}, 64'(in_ready), 64'd1);
    e.gpa = eg; e.err = ee;
    @(posedge clk);
    sb.push_back(e);
    #1;
    // Inputs scrambled after the accept must not disturb the transaction.
    in_valid  = 1'b0;
    mask      = N'({$urandom(), $urandom()});
    pattern   = N'({$urandom(), $urandom()});
    file_num  = N'({$urandom(), $urandom()});
    out_ready = 1'b1;
    cyc = 0; early = 1'b0;
    while (1) begin
      @(posedge clk);
      cyc++;
      #1;
      if (out_valid) break;
      if (gpa != '0 || err || in_ready) early = 1'b1;
      if (cyc > 40) break;
    end
    chk({nm, ":out_valid"}, 64'(out_valid), 64'd1);
    chk({nm, ":latency"}, 64'(cyc + 1), 64'(LAT));
    chk({nm, ":quiet_in_run"}, 64'(early), 64'd0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk({nm, ":hold_stable"}, {9'd0, in_ready, out_valid, err, gpa},
          {9'd0, 1'b0, 1'b1, e.err, e.gpa});
    end
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      chk({nm, ":scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      got = sb.pop_front();
      chk({nm, ":gpa"}, 64'(gpa), 64'(got.gpa));
      chk({nm, ":err"}, 64'(err), 64'(got.err));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, ":after_hs"}, {60'd0, in_ready, out_valid, err, |gpa}, {60'd0, 4'b1000});
  endtask

  initial begin
    logic [N-1:0] m, p, n;
    int   seen;

    tbl[0] = '{52'h0000F, 52'hABC00, 52'h5, 52'hABC05, 1'b0, 0};
    tbl[1] = '{52'hA, 52'h0, 52'h3, 52'hA, 1'b0, 0};
    tbl[2] = '{52'hA, 52'h0, 52'h4, 52'h0, 1'b1, 0};
    tbl[3] = '{52'h0, 52'h12345, 52'h0, 52'h12345, 1'b0, 0};
    tbl[4] = '{52'h0, 52'h12345, 52'h1, 52'h12345, 1'b1, 0};
    tbl[5] = '{52'hF_FFFF_FFFF_FFFF, 52'hFFF, 52'h8_0000_0000_0001, 52'h8_0000_0000_0001, 1'b0, 0};
    tbl[6] = '{52'hF, 52'h0, 52'h2, 52'h2, 1'b0, 5};
    tbl[7] = '{52'h8_0000_0000_0000, 52'h0, 52'h1, 52'h8_0000_0000_0000, 1'b0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mask = '0; pattern = '0; file_num = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {61'd0, out_valid, err, |gpa}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 8; i++)
      txn(tbl[i].mask, tbl[i].pat, tbl[i].num, tbl[i].gpa, tbl[i].err,
          tbl[i].hold, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      m = N'({$urandom(), $urandom()});
      if (i % 2 == 1) m = m & N'({$urandom(), $urandom()});
      p = N'({$urandom(), $urandom()});
      n = N'({$urandom(), $urandom()});
      if (i >= 3) n = n & ((N'(1) << $countones(m)) - N'(1));
      txn(m, p, n, model_gpa(m, p, n), model_err(m, n), i % 3,
          $sformatf("rnd%0d", i));
    end

    // Reset landing on the 5th RUN cycle aborts the transaction.
    @(negedge clk);
    mask = 52'hFF; pattern = 52'h0; file_num = 52'h7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_run_state", {62'd0, in_ready, out_valid}, 64'd2);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("rst_run_no_output", 64'(seen), 64'd0);
    out_ready = 1'b0;
    txn(52'hF, 52'h0, 52'h2, 52'h2, 1'b0, 0, "post_rst");

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
